jtag_tap_master: RTL

- JTAG initiator that drives a 1149.1 TAP from the host side, clocked by TCK.
- Generates the TMS/TDI sequences that walk a target TAP controller into Shift-IR or Shift-DR, shifts up to DATA_W bits LSB-first, captures TDO, and returns to Run-Test/Idle.
- Keeps an internal mirror of the target TAP state machine for sequencing and debug.
- Sits between a command source (test sequencer / bench) and the tap_controller under test.

---
 rtl/jtag_tap_master_if.sv | 24 ++
 rtl/jtag_tap_master.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_master_if.sv
// rtl/jtag_tap_master_if.sv - command/response bundle between a scan sequencer and jtag_tap_master
interface jtag_tap_master_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 6
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_ir;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_ir, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/jtag_tap_master.sv
// rtl/jtag_tap_master.sv - JTAG initiator: walks the target TAP to Shift-IR/DR, shifts LSB-first, returns to RTI
module jtag_tap_master #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 6
) (
    input  logic             TCK,
    input  logic             TRST,
    jtag_tap_master_if.slave bus,
    output logic             TMS,
    output logic             TDI,
    input  logic             TDO,
    output logic [3:0]       tap_state
);
    localparam logic [3:0] tlr = 4'hF, rti = 4'hC, sel_dr = 4'h7, cap_dr = 4'h6;
    localparam logic [3:0] sh_dr = 4'h2, ex1_dr = 4'h1, pause_dr = 4'h3, ex2_dr = 4'h0;
    localparam logic [3:0] upd_dr = 4'h5, sel_ir = 4'h4, cap_ir = 4'hE, sh_ir = 4'hA;
    localparam logic [3:0] ex1_ir = 4'h9, pause_ir = 4'hB, ex2_ir = 4'h8, upd_ir = 4'hD;

    localparam logic [2:0] st_init  = 3'd0;
    localparam logic [2:0] st_idle  = 3'd1;
    localparam logic [2:0] st_nav   = 3'd2;
    localparam logic [2:0] st_shift = 3'd3;
    localparam logic [2:0] st_exit  = 3'd4;
    localparam logic [2:0] st_upd   = 3'd5;
    localparam logic [2:0] st_done  = 3'd6;

    logic [2:0]        state;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len_q;
    logic              ir_q;
    logic [DATA_W-1:0] sh_q;
    logic [DATA_W-1:0] cap_q;
    logic              len_bad;
    logic [LEN_W-1:0]  nav_last;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic t);
        case (s)
            tlr:      tap_next = t ? tlr    : rti;
            rti:      tap_next = t ? sel_dr : rti;
            sel_dr:   tap_next = t ? sel_ir : cap_dr;
            cap_dr:   tap_next = t ? ex1_dr : sh_dr;
            sh_dr:    tap_next = t ? ex1_dr : sh_dr;
            ex1_dr:   tap_next = t ? upd_dr : pause_dr;
            pause_dr: tap_next = t ? ex2_dr : pause_dr;
            ex2_dr:   tap_next = t ? upd_dr : sh_dr;
            upd_dr:   tap_next = t ? sel_dr : rti;
            sel_ir:   tap_next = t ? tlr    : cap_ir;
            cap_ir:   tap_next = t ? ex1_ir : sh_ir;
            sh_ir:    tap_next = t ? ex1_ir : sh_ir;
            ex1_ir:   tap_next = t ? upd_ir : pause_ir;
            pause_ir: tap_next = t ? ex2_ir : pause_ir;
            ex2_ir:   tap_next = t ? upd_ir : sh_ir;
            default:  tap_next = t ? sel_dr : rti;
        endcase
    endfunction

    assign len_bad  = (bus.cmd_len == '0) || (bus.cmd_len > LEN_W'(DATA_W));
    // Navigation is 1,0,0 for DR and 1,1,0,0 for IR; nav_last indexes the final bit.
    assign nav_last = ir_q ? LEN_W'(3) : LEN_W'(2);

    always_ff @(posedge TCK) begin
        if (TRST) begin
            state         <= st_init;
            cnt           <= '0;
            len_q         <= '0;
            ir_q          <= 1'b0;
            sh_q          <= '0;
            cap_q         <= '0;
            TMS           <= 1'b1;
            TDI           <= 1'b0;
            tap_state     <= tlr;
            bus.cmd_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_data  <= '0;
        end else begin
            // The target samples this same TMS on this edge, so the mirror stays in lockstep.
            tap_state     <= tap_next(tap_state, TMS);
            bus.rsp_valid <= 1'b0;
            if (tap_state == sh_dr || tap_state == sh_ir)
                cap_q <= cap_q | (DATA_W'(TDO) << cnt);

            case (state)
                st_init: begin
                    if (tap_state == rti) begin
                        state         <= st_idle;
                        bus.cmd_ready <= 1'b1;
                    end else if (cnt < LEN_W'(4)) begin
                        TMS <= 1'b1;
                        cnt <= cnt + LEN_W'(1);
                    end else begin
                        TMS <= 1'b0;
                    end
                end
                st_idle: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        bus.cmd_ready <= 1'b0;
                        ir_q          <= bus.cmd_ir;
                        len_q         <= bus.cmd_len;
                        sh_q          <= bus.cmd_data;
                        cap_q         <= '0;
                        cnt           <= '0;
                        if (len_bad) begin
                            state <= st_done;
                        end else begin
                            state <= st_nav;
                            TMS   <= 1'b1;
                        end
                    end
                end
                st_nav: begin
                    if (cnt == nav_last) begin
                        state <= st_shift;
                        cnt   <= '0;
                        TMS   <= (len_q == LEN_W'(1));
                        TDI   <= sh_q[0];
                    end else begin
                        TMS <= ir_q && (cnt == '0);
                        cnt <= cnt + LEN_W'(1);
                    end
                end
                st_shift: begin
                    if (cnt == len_q - LEN_W'(1)) begin
                        state <= st_exit;
                        TMS   <= 1'b1;
                        TDI   <= 1'b0;
                    end else begin
                        cnt  <= cnt + LEN_W'(1);
                        TMS  <= (cnt + LEN_W'(2) == len_q);
                        TDI  <= sh_q[1];
                        sh_q <= sh_q >> 1;
                    end
                end
                st_exit: begin
                    state <= st_upd;
                    TMS   <= 1'b0;
                end
                st_upd: begin
                    state         <= st_idle;
                    cnt           <= '0;
                    bus.cmd_ready <= 1'b1;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_data  <= cap_q;
                end
                st_done: begin
                    state         <= st_idle;
                    bus.cmd_ready <= 1'b1;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= 1'b1;
                    bus.rsp_data  <= '0;
                end
                default: begin
                    state <= st_init;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule
